// File: rtl/uart_tx_buffered_if.sv
// Byte-side handshake and line outputs of uart_tx_buffered.
// A byte moves when i_TX_DV and o_TX_Ready are both high at a rising edge;
// i_TX_Byte is sampled at that edge and nothing moves otherwise.
interface uart_tx_buffered_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          i_TX_DV;
    logic [7:0]    i_TX_Byte;
    logic          o_TX_Ready;
    logic          o_TX_Serial;
    logic          o_TX_Active;
    logic          o_TX_Done;
    logic [CW-1:0] o_FIFO_Count;

    modport master (
        output i_TX_DV, i_TX_Byte,
        input  o_TX_Ready, o_TX_Serial, o_TX_Active, o_TX_Done, o_FIFO_Count
    );

    modport slave (
        input  i_TX_DV, i_TX_Byte,
        output o_TX_Ready, o_TX_Serial, o_TX_Active, o_TX_Done, o_FIFO_Count
    );
endinterface

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter; define UART_TX_PARITY_EN to insert an
// even-parity bit between data bit 7 and the stop bit.
module uart_tx_buffered #(
    parameter int CLKS_PER_BIT = 217,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                i_Clock,
    input  logic                i_Reset,
    uart_tx_buffered_if.slave   tx,
    output logic [2:0]          state_dbg
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] CNT_MAX = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] FULL    = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY  = 3'd3,
`endif
        STOP    = 3'd4,
        CLEANUP = 3'd5
    } state_t;

    state_t state, state_next;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          push, pop;

    logic [BW-1:0] clk_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          bit_end, timed;

    logic          serial_q, active_q, done_q;
    logic          line_next, active_next, done_next;

    assign tx.o_TX_Ready   = (count != FULL);
    assign tx.o_FIFO_Count = count;
    assign tx.o_TX_Serial  = serial_q;
    assign tx.o_TX_Active  = active_q;
    assign tx.o_TX_Done    = done_q;
    assign state_dbg       = state;

    assign push    = tx.i_TX_DV && tx.o_TX_Ready;
    assign pop     = (state == IDLE) && (count != '0);
    assign bit_end = (clk_cnt == CNT_MAX);

    // FIFO storage carries no reset; only pointers and count define content.
    always_ff @(posedge i_Clock) begin
        if (push) begin
            mem[wr_ptr] <= tx.i_TX_Byte;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        timed = (state == START) || (state == DATA) || (state == STOP);
`ifdef UART_TX_PARITY_EN
        if (state == PARITY) timed = 1'b1;
`endif
    end

    // Bit timer and shift register: loaded on pop, stepped on bit boundaries.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            clk_cnt <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else if (pop) begin
            shift   <= mem[rd_ptr];
            clk_cnt <= '0;
            bit_idx <= '0;
        end else if (timed) begin
            if (bit_end) begin
                clk_cnt <= '0;
                if (state == DATA) bit_idx <= bit_idx + 1'b1;
            end else begin
                clk_cnt <= clk_cnt + 1'b1;
            end
        end else begin
            clk_cnt <= '0;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (count != '0) state_next = START;
            START:   if (bit_end) state_next = DATA;
            DATA: begin
                if (bit_end && (bit_idx == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY:  if (bit_end) state_next = STOP;
`endif
            STOP:    if (bit_end) state_next = CLEANUP;
            CLEANUP: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        line_next   = 1'b1;
        active_next = 1'b0;
        done_next   = 1'b0;
        case (state)
            START: begin
                line_next   = 1'b0;
                active_next = 1'b1;
            end
            DATA: begin
                line_next   = shift[bit_idx];
                active_next = 1'b1;
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                line_next   = ^shift;
                active_next = 1'b1;
            end
`endif
            STOP:    active_next = 1'b1;
            CLEANUP: done_next   = 1'b1;
            default: line_next   = 1'b1;
        endcase
    end

    // Line outputs are registered, so they trail the state by one cycle.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            serial_q <= 1'b1;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            serial_q <= line_next;
            active_q <= active_next;
            done_q   <= done_next;
        end
    end
endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered: frame-level reference model
// (start edge = max(previous frame end, accept edge) + 2) plus a line monitor.
module tb_uart_tx_buffered;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = NB * CPB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_buffered_if #(.FIFO_DEPTH(DEPTH)) tx_if ();
    logic [2:0] state_dbg;

    uart_tx_buffered #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .i_Clock  (clk),
        .i_Reset  (rst),
        .tx       (tx_if.slave),
        .state_dbg(state_dbg)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] exp_q[$];
    int         start_q[$];
    int         last_end = 0;
    int         checks = 0;
    int         errors = 0;
    int         done_cnt = 0;

    bit         busy = 1'b0;
    bit         done_pend = 1'b0;
    bit         no_exp = 1'b0;
    int         ph = 0;
    logic       samp [FRAME];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        checks++;
        errors++;
        $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
    endtask

    function automatic int model_count(input int e);
        int n = 0;
        foreach (start_q[i]) if (start_q[i] - 1 > e) n++;
        return n;
    endfunction

    task automatic check_frame();
        logic [7:0]    b;
        logic [NB-1:0] fr;
        if (no_exp) return;
        b  = exp_q.pop_front();
        void'(start_q.pop_front());
        fr = '0;
        fr[NB-1] = 1'b1;
        for (int i = 0; i < 8; i++) fr[1+i] = b[i];
`ifdef UART_TX_PARITY_EN
        fr[9] = ^b;
`endif
        for (int k = 0; k < FRAME; k++) chk("frame_bit", {31'd0, samp[k]}, {31'd0, fr[k/CPB]});
    endtask

    // Line monitor: consumes the expected queue whenever a frame appears.
    always @(negedge clk) begin
        if (rst) begin
            busy      = 1'b0;
            done_pend = 1'b0;
        end else if (busy) begin
            samp[ph] = tx_if.o_TX_Serial;
            chk("active_in_frame", {31'd0, tx_if.o_TX_Active}, 32'd1);
            chk("done_in_frame", {31'd0, tx_if.o_TX_Done}, 32'd0);
            ph++;
            if (ph == FRAME) begin
                busy      = 1'b0;
                done_pend = 1'b1;
                check_frame();
            end
        end else begin
            chk("done_pulse", {31'd0, tx_if.o_TX_Done}, {31'd0, done_pend});
            if (tx_if.o_TX_Done === 1'b1) done_cnt++;
            done_pend = 1'b0;
            if (tx_if.o_TX_Serial === 1'b0) begin
                chk("active_at_start", {31'd0, tx_if.o_TX_Active}, 32'd1);
                if (start_q.size() == 0) begin
                    fail_now("unexpected_frame", "got start bit, required idle line");
                    no_exp = 1'b1;
                end else begin
                    no_exp = 1'b0;
                    chk("start_edge", cyc, start_q[0]);
                end
                busy    = 1'b1;
                samp[0] = 1'b0;
                ph      = 1;
            end else begin
                chk("line_idle_high", {31'd0, tx_if.o_TX_Serial}, 32'd1);
                chk("active_idle", {31'd0, tx_if.o_TX_Active}, 32'd0);
            end
        end
    end

    // One driver cycle, entered 1 time unit after a rising edge.
    task automatic step(input bit dv, input logic [7:0] b);
        int cnt;
        int s;
        tx_if.i_TX_DV   = dv;
        tx_if.i_TX_Byte = b;
        cnt = model_count(cyc);
        chk("fifo_count", {29'd0, tx_if.o_FIFO_Count}, cnt);
        chk("tx_ready", {31'd0, tx_if.o_TX_Ready}, {31'd0, (cnt != DEPTH)});
        if (dv && cnt != DEPTH) begin
            s = ((last_end > cyc + 1) ? last_end : cyc + 1) + 2;
            exp_q.push_back(b);
            start_q.push_back(s);
            last_end = s + FRAME;
        end
        @(posedge clk);
        #1;
        tx_if.i_TX_DV = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((exp_q.size() != 0 || busy || done_pend) && t < 3000) begin
            step(1'b0, 8'h00);
            t++;
        end
        if (t >= 3000) fail_now("timeout_idle", "frames still pending after 3000 cycles");
        repeat (3) step(1'b0, 8'h00);
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        tx_if.i_TX_DV = 1'b0;
        exp_q.delete();
        start_q.delete();
        last_end = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_serial", {31'd0, tx_if.o_TX_Serial}, 32'd1);
        chk("rst_active", {31'd0, tx_if.o_TX_Active}, 32'd0);
        chk("rst_done", {31'd0, tx_if.o_TX_Done}, 32'd0);
        chk("rst_count", {29'd0, tx_if.o_FIFO_Count}, 32'd0);
        chk("rst_ready", {31'd0, tx_if.o_TX_Ready}, 32'd1);
    endtask

    initial begin
        int d0;
        int target;
        tx_if.i_TX_DV   = 1'b0;
        tx_if.i_TX_Byte = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        do_reset();

        // single byte
        d0 = done_cnt;
        step(1'b1, 8'hA5);
        wait_idle();
        chk("a5_done_count", done_cnt - d0, 1);

        // back-to-back
        d0 = done_cnt;
        step(1'b1, 8'h00);
        step(1'b1, 8'hFF);
        step(1'b1, 8'h3C);
        step(1'b1, 8'h81);
        chk("b2b_count", {29'd0, tx_if.o_FIFO_Count}, 32'd3);
        wait_idle();
        chk("b2b_done_count", done_cnt - d0, 4);

        // overflow: byte 6 must be dropped
        d0 = done_cnt;
        for (int i = 1; i <= 6; i++) step(1'b1, 8'(i));
        chk("ovf_count", {29'd0, tx_if.o_FIFO_Count}, 32'd4);
        chk("ovf_ready", {31'd0, tx_if.o_TX_Ready}, 32'd0);
        wait_idle();
        chk("ovf_done_count", done_cnt - d0, 5);

        // push coinciding with the IDLE pop while count=2
        d0 = done_cnt;
        step(1'b1, 8'h11);
        step(1'b1, 8'h22);
        step(1'b1, 8'h33);
        target = start_q[0] + FRAME;
        while (cyc < target) step(1'b0, 8'h00);
        step(1'b1, 8'h44);
        chk("pushpop_count", {29'd0, tx_if.o_FIFO_Count}, 32'd2);
        wait_idle();
        chk("pushpop_done_count", done_cnt - d0, 4);

        // reset during data bit 3 of the first of two frames
        step(1'b1, 8'hC3);
        step(1'b1, 8'h96);
        target = start_q[0] + 4 * CPB;
        while (cyc < target) step(1'b0, 8'h00);
        d0 = done_cnt;
        do_reset();
        repeat (2 * FRAME) step(1'b0, 8'h00);
        chk("rst_no_done", done_cnt - d0, 0);
        step(1'b1, 8'h5A);
        wait_idle();
        chk("post_rst_done_count", done_cnt - d0, 1);

`ifdef UART_TX_PARITY_EN
        step(1'b1, 8'h07);
        wait_idle();
        step(1'b1, 8'h03);
        wait_idle();
`endif

        // randomized bursts and gaps
        for (int it = 0; it < 30; it++) begin
            int gap;
            int len;
            gap = $urandom_range(0, 50);
            len = $urandom_range(1, 6);
            repeat (gap) step(1'b0, 8'h00);
            repeat (len) step(1'b1, 8'($urandom_range(0, 255)));
        end
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_tx_buffered.md
# uart_tx_buffered

UART transmitter with a small input FIFO. Serialises 8-bit bytes as 8N1 (one start bit, eight data bits LSB first, one stop bit). An optional even-parity bit can be compiled in. Sits between the byte-producing application logic and the FPGA TX pin, and mirrors the framing and bit timing of the existing UART receiver so the two ends interoperate at the same CLKS_PER_BIT.

## Interface
- CLKS_PER_BIT, 217 — clock cycles per serial bit, computed as f_clk / baud; must be ≥ 2.
- FIFO_DEPTH, 4 — input FIFO entries; must be a power of 2 and ≥ 2.
- i_Clock  in  1  — sole clock; all logic on the rising edge.
- i_Reset  in  1  — synchronous, active-high reset.
- i_TX_DV  in  1  — write strobe. The byte is accepted when i_TX_DV && o_TX_Ready.
- i_TX_Byte  in  8  — byte to send; sampled on acceptance.
- o_TX_Ready  out  1  — FIFO not full.
- o_TX_Serial  out  1  — serial line; idles high; registered.
- o_TX_Active  out  1  — high while a frame is on the line, from the start bit through the stop bit.
- o_TX_Done  out  1  — one-cycle pulse after each stop bit completes.
- o_FIFO_Count  out  $clog2(FIFO_DEPTH)+1  — number of bytes queued, excluding the byte in flight.

## Operation
- The FIFO is a circular buffer with read/write pointers of width $clog2(FIFO_DEPTH); the pointers wrap naturally.
- o_TX_Ready = (o_FIFO_Count != FIFO_DEPTH), derived combinationally from the count register.
- A write while full is ignored. Data is not corrupted, and the count does not change.
- Push and pop in the same cycle: the count is unchanged and both pointers advance.
- A push blocked by full is not rescued by a same-cycle pop, because Ready is low.
- State machine states: IDLE, START, DATA, PARITY (only when the macro is defined), STOP, CLEANUP.
  - IDLE: line high. If the FIFO is non-empty, pop the head byte into the shift register, clear the bit counter and bit index, and go to START.
  - START: line 0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: line = shift[bit_index] for CLKS_PER_BIT cycles per bit, index 0..7. After index 7, go to PARITY or STOP.
  - PARITY: line = ^byte (even parity) for CLKS_PER_BIT cycles, then go to STOP.
  - STOP: line 1 for CLKS_PER_BIT cycles, then go to CLEANUP with o_TX_Done asserted.
  - CLEANUP: one cycle, line high, o_TX_Done deasserts, then go to IDLE.
- The bit counter has width $clog2(CLKS_PER_BIT), counts 0..CLKS_PER_BIT-1, and resets on every bit boundary.
- Unused or illegal state encodings return to IDLE and force the line high.

## Timing
- Reset values: o_TX_Serial=1, o_TX_Active=0, o_TX_Done=0, o_FIFO_Count=0, o_TX_Ready=1. State is IDLE; pointers and counters are 0.
- Reset mid-frame:
  - The line returns high on the cycle after reset is sampled.
  - The FIFO is flushed and the in-flight byte is dropped.
  - No o_TX_Done pulse is issued.
- Latency: byte accepted at edge N into an empty FIFO while IDLE.
  - Pop at edge N+1.
  - o_TX_Serial falls and o_TX_Active rises at edge N+2.
- Each bit occupies exactly CLKS_PER_BIT cycles on the line.
- Frame length is 10·CLKS_PER_BIT cycles, or 11·CLKS_PER_BIT with parity.
- o_TX_Active deasserts, and o_TX_Done pulses for one cycle, at the edge that ends the stop bit.
- Back-to-back frames: exactly 2 idle-high cycles (CLEANUP plus IDLE pop) between the end of one stop bit and the next start bit.
- o_FIFO_Count decrements at the pop edge (edge N+1 above).

## Configuration
- UART_TX_PARITY_EN defined:
  - The PARITY state is present.
  - One even-parity bit is inserted between data bit 7 and the stop bit.
  - Frame length becomes 11·CLKS_PER_BIT.
- UART_TX_PARITY_EN undefined:
  - No PARITY state and no parity logic.
  - Plain 8N1 framing, 10·CLKS_PER_BIT per frame.

## Test plan
Bench uses CLKS_PER_BIT=4 and FIFO_DEPTH=4 unless stated.
- Single byte 0xA5 written after reset:
  - Line low at write+2 for 4 cycles.
  - Data bits 1,0,1,0,0,1,0,1, 4 cycles each.
  - Stop bit high for 4 cycles.
  - o_TX_Done pulses once at frame end.
  - Loopback through the existing UART receiver returns 0xA5.
- Write 0x00, 0xFF, 0x3C, 0x81 back-to-back:
  - Count reaches 3, because the first byte pops.
  - Four frames go out in order, each separated by exactly 2 high cycles.
  - Four Done pulses.
- Overflow:
  - Hold i_TX_DV for 6 cycles with bytes 1..6 while the first frame is in flight.
  - Ready drops when count=4.
  - Bytes 1–5 are transmitted; byte 6 is dropped.
- Simultaneous push/pop:
  - Time a write to coincide with the IDLE pop cycle while count=2.
  - Count stays 2 and the order is preserved.
- Reset mid-frame:
  - Assert i_Reset during data bit 3 of the first of two queued frames.
  - The line is high the next cycle, count=0, and no Done pulse.
  - The next byte written after reset transmits correctly.
- UART_TX_PARITY_EN defined, byte 0x07:
  - Parity bit = 1; byte 0x03 gives parity bit 0.
  - Frame is 44 cycles.
